// File: rtl/sha256_block_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sha256_block_sequencer_if: word stream, digest stream and core bus.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface sha256_block_sequencer_if;
  logic         blk_valid;
  logic         blk_ready;
  logic [31:0]  blk_data;
  logic         blk_first;
  logic         blk_last;
  logic [255:0] digest_data;
  logic         digest_valid;
  logic         digest_ready;
  logic         sha_cs;
  logic         sha_we;
  logic [7:0]   sha_address;
  logic [31:0]  sha_write_data;
  logic [31:0]  sha_read_data;
  logic         sha_error;

  modport master (
    input  blk_valid, blk_data, blk_first, blk_last, digest_ready,
           sha_read_data, sha_error,
    output blk_ready, digest_data, digest_valid,
           sha_cs, sha_we, sha_address, sha_write_data
  );

  modport slave (
    output blk_valid, blk_data, blk_first, blk_last, digest_ready,
           sha_read_data, sha_error,
    input  blk_ready, digest_data, digest_valid,
           sha_cs, sha_we, sha_address, sha_write_data
  );
endinterface
`default_nettype wire

// File: rtl/sha256_block_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sha256_block_sequencer: loads 16-word blocks into a SHA-256 core,    |
// | polls for completion and returns the digest. Revision: 1.0           |
// +----------------------------------------------------------------------+
module sha256_block_sequencer #(
  parameter int POLL_GAP       = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                             clk,
  input  logic                             reset_n,
  sha256_block_sequencer_if.master         bus,
  output logic                             busy,
  output logic                             timeout_err,
  output logic                             core_err,
  input  logic                             clear_err
);

  localparam logic [2:0] c_st_idle = 3'd0;
  localparam logic [2:0] c_st_load = 3'd1;
  localparam logic [2:0] c_st_ctrl = 3'd2;
  localparam logic [2:0] c_st_gap  = 3'd3;
  localparam logic [2:0] c_st_poll = 3'd4;
  localparam logic [2:0] c_st_rdig = 3'd5;
  localparam logic [2:0] c_st_out  = 3'd6;
  localparam logic [2:0] c_st_err  = 3'd7;

  localparam logic [7:0] c_addr_ctrl   = 8'h08;
  localparam logic [7:0] c_addr_status = 8'h09;
  localparam logic [7:0] c_addr_block  = 8'h10;
  localparam logic [7:0] c_addr_digest = 8'h20;

  logic [2:0]   r_state, w_state;
  logic [3:0]   r_idx, w_idx;
  logic         r_first, w_first;
  logic         r_last, w_last;
  logic [3:0]   r_gap, w_gap;
  logic [9:0]   r_cnt, w_cnt;
  logic         r_blk_ready, w_blk_ready;
  logic [255:0] r_digest, w_digest;
  logic         r_digest_valid, w_digest_valid;
  logic         r_busy, w_busy;
  logic         r_timeout_err, w_timeout_err;
  logic         r_core_err, w_core_err;
  logic         r_cs, w_cs;
  logic         r_we, w_we;
  logic [7:0]   r_addr, w_addr;
  logic [31:0]  r_wdata, w_wdata;

  always_comb begin
    w_state        = r_state;
    w_idx          = r_idx;
    w_first        = r_first;
    w_last         = r_last;
    w_gap          = r_gap;
    w_cnt          = r_cnt;
    w_blk_ready    = 1'b0;
    w_digest       = r_digest;
    w_digest_valid = 1'b0;
    w_timeout_err  = r_timeout_err;
    w_core_err     = r_core_err;
    w_cs           = 1'b0;
    w_we           = 1'b0;
    w_addr         = r_addr;
    w_wdata        = r_wdata;

    // A core error aborts whatever access is on the bus this cycle.
    if (r_cs && bus.sha_error) begin
      w_core_err = 1'b1;
      w_state    = c_st_err;
    end else begin
      case (r_state)
        c_st_idle: begin
          w_blk_ready = 1'b1;
          if (bus.blk_valid && r_blk_ready) begin
            w_first     = bus.blk_first;
            w_last      = bus.blk_last;
            w_cs        = 1'b1;
            w_we        = 1'b1;
            w_addr      = c_addr_block;
            w_wdata     = bus.blk_data;
            w_idx       = 4'd1;
            w_state     = c_st_load;
          end
        end
        c_st_load: begin
          // blk_ready low here means word 15 is being written right now.
          if (!r_blk_ready) begin
            w_cs    = 1'b1;
            w_we    = 1'b1;
            w_addr  = c_addr_ctrl;
            w_wdata = r_first ? 32'h0000_0005 : 32'h0000_0006;
            w_state = c_st_ctrl;
          end else begin
            w_blk_ready = 1'b1;
            if (bus.blk_valid) begin
              w_cs    = 1'b1;
              w_we    = 1'b1;
              w_addr  = c_addr_block | {4'h0, r_idx};
              w_wdata = bus.blk_data;
              w_idx   = r_idx + 4'd1;
              if (r_idx == 4'd15) w_blk_ready = 1'b0;
            end
          end
        end
        c_st_ctrl: begin
          w_gap   = 4'(POLL_GAP - 1);
          w_state = c_st_gap;
        end
        c_st_gap: begin
          if (r_gap == 4'd0) begin
            w_cs    = 1'b1;
            w_addr  = c_addr_status;
            w_cnt   = 10'd0;
            w_state = c_st_poll;
          end else begin
            w_gap = r_gap - 4'd1;
          end
        end
        c_st_poll: begin
          w_cnt = r_cnt + 10'd1;
          if (bus.sha_read_data[0]) begin
            if (r_last) begin
              w_cs    = 1'b1;
              w_addr  = c_addr_digest;
              w_idx   = 4'd0;
              w_state = c_st_rdig;
            end else begin
              w_blk_ready = 1'b1;
              w_state     = c_st_idle;
            end
          end else if ((r_cnt + 10'd1) == 10'(TIMEOUT_CYCLES)) begin
            w_timeout_err = 1'b1;
            w_state       = c_st_err;
          end else begin
            w_cs   = 1'b1;
            w_addr = c_addr_status;
          end
        end
        c_st_rdig: begin
          for (int k = 0; k < 8; k++) begin
            if (r_idx[2:0] == k[2:0]) w_digest[255-32*k -: 32] = bus.sha_read_data;
          end
          if (r_idx == 4'd7) begin
            w_digest_valid = 1'b1;
            w_state        = c_st_out;
          end else begin
            w_cs   = 1'b1;
            w_addr = r_addr + 8'd1;
            w_idx  = r_idx + 4'd1;
          end
        end
        c_st_out: begin
          w_digest_valid = 1'b1;
          if (bus.digest_ready && r_digest_valid) begin
            w_digest_valid = 1'b0;
            w_blk_ready    = 1'b1;
            w_state        = c_st_idle;
          end
        end
        c_st_err: begin
          if (clear_err) begin
            w_timeout_err = 1'b0;
            w_core_err    = 1'b0;
            w_blk_ready   = 1'b1;
            w_state       = c_st_idle;
          end
        end
        default: w_state = c_st_idle;
      endcase
    end
    w_busy = (w_state != c_st_idle) && (w_state != c_st_err);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= c_st_idle;
      r_idx          <= 4'd0;
      r_first        <= 1'b0;
      r_last         <= 1'b0;
      r_gap          <= 4'd0;
      r_cnt          <= 10'd0;
      r_blk_ready    <= 1'b0;
      r_digest       <= 256'd0;
      r_digest_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_core_err     <= 1'b0;
      r_cs           <= 1'b0;
      r_we           <= 1'b0;
      r_addr         <= 8'd0;
      r_wdata        <= 32'd0;
    end else begin
      r_state        <= w_state;
      r_idx          <= w_idx;
      r_first        <= w_first;
      r_last         <= w_last;
      r_gap          <= w_gap;
      r_cnt          <= w_cnt;
      r_blk_ready    <= w_blk_ready;
      r_digest       <= w_digest;
      r_digest_valid <= w_digest_valid;
      r_busy         <= w_busy;
      r_timeout_err  <= w_timeout_err;
      r_core_err     <= w_core_err;
      r_cs           <= w_cs;
      r_we           <= w_we;
      r_addr         <= w_addr;
      r_wdata        <= w_wdata;
    end
  end

  assign bus.blk_ready      = r_blk_ready;
  assign bus.digest_data    = r_digest;
  assign bus.digest_valid   = r_digest_valid;
  assign bus.sha_cs         = r_cs;
  assign bus.sha_we         = r_we;
  assign bus.sha_address    = r_addr;
  assign bus.sha_write_data = r_wdata;
  assign busy               = r_busy;
  assign timeout_err        = r_timeout_err;
  assign core_err           = r_core_err;

endmodule
`default_nettype wire

// File: tb/tb_sha256_block_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sha256_block_sequencer: sequencer against a behavioural SHA-256   |
// | core, with write/digest scoreboards. Revision: 1.0                   |
// +----------------------------------------------------------------------+
module tb_sha256_block_sequencer;

  localparam logic [511:0] c_blk_abc = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] c_blk_m1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] c_blk_m2  = {480'h0, 32'h000001c0};
  localparam logic [255:0] c_dig_abc = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] c_dig_m   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [31:0] c_k [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [31:0] c_iv [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  logic clk = 1'b0;
  logic reset_n;
  logic busy, timeout_err, core_err, clear_err;

  sha256_block_sequencer_if bus ();

  sha256_block_sequencer #(.POLL_GAP(2), .TIMEOUT_CYCLES(1023)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus.master),
    .busy        (busy),
    .timeout_err (timeout_err),
    .core_err    (core_err),
    .clear_err   (clear_err)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural core: block/hash registers updated on the falling edge,
  // read data combinational from its state.
  logic [31:0] cblk [16];
  logic [31:0] hreg [8];
  int          busy_cnt = 0;
  logic        stuck    = 1'b0;
  logic        inj_err  = 1'b0;
  logic        model_ready;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic sha_compress();
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = cblk[i];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3))
           + w[i-7] + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
    a = hreg[0]; b = hreg[1]; c = hreg[2]; d = hreg[3];
    e = hreg[4]; f = hreg[5]; g = hreg[6]; h = hreg[7];
    for (int i = 0; i < 64; i++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + c_k[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    hreg[0] += a; hreg[1] += b; hreg[2] += c; hreg[3] += d;
    hreg[4] += e; hreg[5] += f; hreg[6] += g; hreg[7] += h;
  endtask

  always @(negedge clk) begin
    if (bus.sha_cs && bus.sha_we && !bus.sha_error) begin
      if (bus.sha_address[7:4] == 4'h1) cblk[bus.sha_address[3:0]] = bus.sha_write_data;
      else if (bus.sha_address == 8'h08) begin
        if (bus.sha_write_data[0]) for (int i = 0; i < 8; i++) hreg[i] = c_iv[i];
        sha_compress();
        busy_cnt = 4;
      end
    end else if (busy_cnt > 0) busy_cnt--;
  end

  assign model_ready   = (busy_cnt == 0) && !stuck;
  assign bus.sha_error = inj_err && bus.sha_cs && bus.sha_we && (bus.sha_address == 8'h14);

  always_comb begin
    bus.sha_read_data = 32'h0;
    if (bus.sha_address == 8'h09) bus.sha_read_data = {30'h0, model_ready, model_ready};
    else if (bus.sha_address[7:3] == 5'b00100) bus.sha_read_data = hreg[bus.sha_address[2:0]];
  end

  // Scoreboards and bus monitor.
  logic [39:0]  exp_wr [$];
  logic [255:0] exp_dig [$];
  int   cyc = 0, wr_count = 0, polls = 0, dv_rises = 0;
  int   err_cyc = -100, cerr_cyc = -200;
  logic cs_at_cerr = 1'b1;
  logic dv_prev = 1'b0, cerr_prev = 1'b0;
  logic [39:0] exp_e;

  always @(negedge clk) begin
    cyc++;
    if (bus.sha_cs && bus.sha_we) begin
      wr_count++;
      if (exp_wr.size() == 0) check("unexpected_write", {bus.sha_address, bus.sha_write_data}, 40'h0);
      else begin
        exp_e = exp_wr.pop_front();
        check("core_write", {bus.sha_address, bus.sha_write_data}, exp_e);
      end
      if (bus.sha_error) err_cyc = cyc;
    end
    if (bus.sha_cs && !bus.sha_we && bus.sha_address == 8'h09) polls++;
    if (bus.digest_valid && !dv_prev) dv_rises++;
    if (core_err && !cerr_prev) begin
      cerr_cyc   = cyc;
      cs_at_cerr = bus.sha_cs;
    end
    dv_prev   = bus.digest_valid;
    cerr_prev = core_err;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_block(input logic [511:0] blk, input logic first, input logic last,
                            input int nwords, input logic [255:0] dig);
    int   k = 0;
    int   guard = 0;
    logic hs;
    logic [31:0] word;
    @(posedge clk); #1;
    while (k < nwords && guard < 200) begin
      word          = blk[511-32*k -: 32];
      bus.blk_valid = 1'b1;
      bus.blk_data  = word;
      // first/last on words 1..15 must be ignored, so drive them inverted there.
      bus.blk_first = (k == 0) ? first : ~first;
      bus.blk_last  = (k == 0) ? last  : ~last;
      @(negedge clk);
      hs = bus.blk_ready;
      @(posedge clk); #1;
      if (hs) begin
        exp_wr.push_back({8'h10 + 8'(k), word});
        k++;
      end
      guard++;
    end
    bus.blk_valid = 1'b0;
    if (k == 16) begin
      exp_wr.push_back({8'h08, first ? 32'h5 : 32'h6});
      if (last) exp_dig.push_back(dig);
    end
    if (k < nwords) check("send_accept", 256'(k), 256'(nwords));
  endtask

  task automatic wait_digest();
    int g = 0;
    logic [255:0] e;
    while (!bus.digest_valid && g < 300) begin step(); g++; end
    if (!bus.digest_valid) check("digest_wait", 256'(bus.digest_valid), 256'd1);
    else if (exp_dig.size() == 0) check("digest_unexpected", bus.digest_data, 256'h0);
    else begin
      e = exp_dig.pop_front();
      check("digest", bus.digest_data, e);
    end
  endtask

  task automatic release_digest();
    @(posedge clk); #1 bus.digest_ready = 1'b1;
    @(posedge clk); #1 bus.digest_ready = 1'b0;
    step();
    check("release_idle", {bus.digest_valid, bus.blk_ready, busy}, 3'b010);
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 clear_err = 1'b1;
    @(posedge clk); #1 clear_err = 1'b0;
    step();
    check("clear_err", {timeout_err, core_err, bus.blk_ready, busy}, 4'b0010);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int wc0, dv0, p0, g;
    reset_n          = 1'b0;
    clear_err        = 1'b0;
    bus.blk_valid    = 1'b0;
    bus.blk_data     = 32'h0;
    bus.blk_first    = 1'b0;
    bus.blk_last     = 1'b0;
    bus.digest_ready = 1'b0;
    repeat (3) step();
    check("reset_digest", bus.digest_data, 256'h0);
    check("reset_outputs", {bus.blk_ready, bus.digest_valid, busy, timeout_err, core_err,
                            bus.sha_cs, bus.sha_we, bus.sha_address, bus.sha_write_data}, 47'h0);
    @(posedge clk); #1 reset_n = 1'b1;
    step(); step();
    check("idle_ready", {bus.blk_ready, busy}, 2'b10);

    // Single-block "abc".
    wc0 = wr_count;
    send_block(c_blk_abc, 1'b1, 1'b1, 16, c_dig_abc);
    wait_digest();
    check("abc_write_count", 256'(wr_count - wc0), 256'd17);
    check("abc_queue_empty", 256'(exp_wr.size()), 256'd0);
    release_digest();

    // Two-block message: no digest after block 1.
    dv0 = dv_rises;
    send_block(c_blk_m1, 1'b1, 1'b0, 16, 256'h0);
    g = 0;
    while (busy && g < 200) begin step(); g++; end
    check("blk1_idle", {bus.blk_ready, busy}, 2'b10);
    check("blk1_no_digest", 256'(dv_rises - dv0), 256'd0);
    send_block(c_blk_m2, 1'b0, 1'b1, 16, c_dig_m);
    wait_digest();
    check("two_block_queue_empty", 256'(exp_wr.size()), 256'd0);
    release_digest();

    // Back-pressure on the digest output.
    send_block(c_blk_abc, 1'b1, 1'b1, 16, c_dig_abc);
    wait_digest();
    wc0 = wr_count;
    for (int i = 0; i < 50; i++) begin
      step();
      check("hold_data", bus.digest_data, c_dig_abc);
      check("hold_ctl", {bus.digest_valid, bus.blk_ready, bus.sha_cs, busy}, 4'b1001);
    end
    check("hold_no_access", 256'(wr_count - wc0), 256'd0);
    release_digest();

    // STATUS never ready.
    stuck = 1'b1;
    p0    = polls;
    send_block(c_blk_abc, 1'b1, 1'b0, 16, 256'h0);
    g = 0;
    while (!timeout_err && g < 1500) begin step(); g++; end
    check("timeout_polls", 256'(polls - p0), 256'd1023);
    check("timeout_flags", {timeout_err, core_err, bus.blk_ready, busy}, 4'b1000);
    stuck = 1'b0;
    pulse_clear();

    // Core error on the 5th BLOCK write.
    inj_err = 1'b1;
    wc0     = wr_count;
    send_block(c_blk_abc, 1'b1, 1'b1, 5, 256'h0);
    g = 0;
    while (!core_err && g < 30) begin step(); g++; end
    check("cerr_latency", 256'(cerr_cyc - err_cyc), 256'd1);
    check("cerr_cs_low", 256'(cs_at_cerr), 256'd0);
    repeat (10) step();
    check("err_state", {core_err, timeout_err, bus.blk_ready, busy, bus.sha_cs}, 5'b10000);
    check("err_writes", 256'(wr_count - wc0), 256'd5);
    check("err_no_ctrl", 256'(exp_wr.size()), 256'd0);
    inj_err = 1'b0;
    pulse_clear();

    // Reset after seven words, then a fresh message.
    send_block(c_blk_abc, 1'b1, 1'b1, 7, 256'h0);
    step(); step();
    check("partial_written", 256'(exp_wr.size()), 256'd0);
    @(posedge clk); #3 reset_n = 1'b0;
    #1;
    check("async_reset_digest", bus.digest_data, 256'h0);
    check("async_reset_outputs", {bus.blk_ready, bus.digest_valid, busy, timeout_err, core_err,
                                  bus.sha_cs, bus.sha_we, bus.sha_address, bus.sha_write_data}, 47'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    step();
    send_block(c_blk_abc, 1'b1, 1'b1, 16, c_dig_abc);
    wait_digest();
    release_digest();
    check("final_queues", 256'(exp_wr.size() + exp_dig.size()), 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
